// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the Flappy Bird game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int BCD_W = 12;
  localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle between the game sequencer and its neighbours (debouncer, collision
// detector, bird/pipe generators, score display).
interface game_ctrl_if;
  import game_pkg::*;

  // No valid/ready here: inputs are levels sampled every clock, and init/flap
  // are single-cycle strobes that consumers must act on in the cycle they are high.
  logic             frame_tick;
  logic             btn;
  logic             crash;
  logic             pass;
  logic [1:0]       state;
  logic             run;
  logic             fall;
  logic             init;
  logic             flap;
  logic [BCD_W-1:0] score;
  logic [BCD_W-1:0] best;
  logic             new_best;

  modport master (
    output frame_tick, btn, crash, pass,
    input  state, run, fall, init, flap, score, best, new_best
  );

  modport slave (
    input  frame_tick, btn, crash, pass,
    output state, run, fall, init, flap, score, best, new_best
  );

endinterface

// File: rtl/game_ctrl_bcd_inc3.sv
// Three-digit BCD increment that sticks at 999 instead of wrapping.
module bcd_inc3
  import game_pkg::*;
(
  input  logic [BCD_W-1:0] val_i,
  output logic [BCD_W-1:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (val_i != BCD_MAX) begin
      if (val_i[3:0] != 4'd9) begin
        val_o[3:0] = val_i[3:0] + 4'd1;
      end else begin
        val_o[3:0] = 4'd0;
        if (val_i[7:4] != 4'd9) begin
          val_o[7:4] = val_i[7:4] + 4'd1;
        end else begin
          val_o[7:4]  = 4'd0;
          val_o[11:8] = val_i[11:8] + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE -> PLAY -> DYING -> OVER, motion gating, BCD score/best.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] DIE_FRAMES = 8'd60,
  parameter logic [7:0] OVER_LOCK  = 8'd30
) (
  input  logic        clk,
  input  logic        rst_n,
  game_ctrl_if.slave  bus
);

  state_e           state_q;
  logic             btn_q;
  logic             pass_q;
  logic             init_q;
  logic             flap_q;
  logic             new_best_q;
  logic [7:0]       frame_cnt_q;
  logic [BCD_W-1:0] score_q;
  logic [BCD_W-1:0] best_q;
  logic [BCD_W-1:0] score_d;
  logic             btn_rise;
  logic             pass_rise;

  assign btn_rise  = bus.btn & ~btn_q;
  assign pass_rise = bus.pass & ~pass_q;

  bcd_inc3 u_inc (
    .val_i (score_q),
    .val_o (score_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      btn_q       <= 1'b0;
      pass_q      <= 1'b0;
      init_q      <= 1'b0;
      flap_q      <= 1'b0;
      new_best_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
      score_q     <= '0;
      best_q      <= '0;
    end else begin
      btn_q  <= bus.btn;
      pass_q <= bus.pass;
      init_q <= 1'b0;
      flap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_rise) begin
            state_q     <= ST_PLAY;
            init_q      <= 1'b1;
            score_q     <= '0;
            new_best_q  <= 1'b0;
            frame_cnt_q <= 8'd0;
          end
        end
        ST_PLAY: begin
          // A crash wins over both scoring and flapping in the same cycle.
          if (bus.crash) begin
            state_q     <= ST_DYING;
            frame_cnt_q <= 8'd0;
          end else begin
            if (pass_rise) score_q <= score_d;
            if (btn_rise)  flap_q  <= 1'b1;
          end
        end
        ST_DYING: begin
          if (bus.frame_tick) begin
            if (frame_cnt_q == DIE_FRAMES - 8'd1) begin
              state_q     <= ST_OVER;
              frame_cnt_q <= 8'd0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        ST_OVER: begin
          // Score is frozen here, so this fires once on the first OVER cycle.
          if (score_q > best_q) begin
            best_q     <= score_q;
            new_best_q <= 1'b1;
          end
          if (btn_rise && frame_cnt_q == OVER_LOCK) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= 8'd0;
          end else if (bus.frame_tick && frame_cnt_q < OVER_LOCK) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.state    = state_q;
  assign bus.run      = (state_q == ST_PLAY);
  assign bus.fall     = (state_q == ST_DYING);
  assign bus.init     = init_q;
  assign bus.flap     = flap_q;
  assign bus.score    = score_q;
  assign bus.best     = best_q;
  assign bus.new_best = new_best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed scoreboard bench for game_ctrl with DIE_FRAMES=3, OVER_LOCK=2.
module tb_game_ctrl;

  localparam int W = 31;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];

  game_ctrl_if bus();

  game_ctrl #(
    .DIE_FRAMES (8'd3),
    .OVER_LOCK  (8'd2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] snap(input logic [1:0] st, input logic ini,
                                        input logic fl, input logic [11:0] sc,
                                        input logic [11:0] bs, input logic nb);
    return {st, (st == 2'd1), (st == 2'd2), ini, fl, sc, bs, nb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string nm, input int at, input logic [W-1:0] v);
    exp_q.push_back(v);
    cyc_q.push_back(at);
    name_q.push_back(nm);
  endtask

  task automatic expect_now(input string nm, input logic [W-1:0] v);
    expect_at(nm, cyc, v);
  endtask

  task automatic expect_next(input string nm, input logic [W-1:0] v);
    expect_at(nm, cyc + 1, v);
  endtask

  task automatic ftick();
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pass_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pass = 1'b1;
      tick();
      bus.pass = 1'b0;
      tick();
    end
  endtask

  task automatic start_game(input string nm, input logic [11:0] bs);
    bus.btn = 1'b1;
    expect_next(nm, snap(2'd1, 1'b1, 1'b0, 12'h000, bs, 1'b0));
    tick();
    bus.btn = 1'b0;
    tick();
  endtask

  task automatic crash_it(input logic [11:0] sc, input logic [11:0] bs);
    bus.crash = 1'b1;
    bus.pass  = 1'b1;
    bus.btn   = 1'b1;
    expect_next("crash", snap(2'd2, 1'b0, 1'b0, sc, bs, 1'b0));
    tick();
    bus.crash = 1'b0;
    bus.pass  = 1'b0;
    bus.btn   = 1'b0;
    tick();
  endtask

  task automatic die_over(input logic [11:0] sc, input logic [11:0] bs_old,
                          input logic [11:0] bs_new, input logic nb_new);
    ftick();
    bus.btn  = 1'b1;
    bus.pass = 1'b1;
    tick();
    bus.btn  = 1'b0;
    bus.pass = 1'b0;
    ftick();
    expect_now("dying_hold", snap(2'd2, 1'b0, 1'b0, sc, bs_old, 1'b0));
    bus.frame_tick = 1'b1;
    expect_next("over_entry", snap(2'd3, 1'b0, 1'b0, sc, bs_old, 1'b0));
    tick();
    bus.frame_tick = 1'b0;
    expect_next("best_update", snap(2'd3, 1'b0, 1'b0, sc, bs_new, nb_new));
    tick();
  endtask

  task automatic unlock(input logic [11:0] sc, input logic [11:0] bs, input logic nb);
    ftick();
    bus.btn = 1'b1;
    expect_next("lock_ignore", snap(2'd3, 1'b0, 1'b0, sc, bs, nb));
    tick();
    bus.btn = 1'b0;
    ftick();
    expect_now("no_queue", snap(2'd3, 1'b0, 1'b0, sc, bs, nb));
    ftick();
    bus.btn = 1'b1;
    expect_next("unlock_idle", snap(2'd0, 1'b0, 1'b0, sc, bs, nb));
    tick();
    bus.btn = 1'b0;
    tick();
    expect_now("idle_keep", snap(2'd0, 1'b0, 1'b0, sc, bs, nb));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    got = {bus.state, bus.run, bus.fall, bus.init, bus.flap,
           bus.score, bus.best, bus.new_best};
    while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
      n_cmp = n_cmp + 1;
      if (cyc_q[0] < cyc) begin
        n_err = n_err + 1;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                 name_q[0], cyc_q[0], cyc);
      end else if (got !== exp_q[0]) begin
        n_err = n_err + 1;
        $display("FAIL %s: got %h required %h", name_q[0], got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      void'(cyc_q.pop_front());
      void'(name_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    bus.btn   = 1'b0;
    bus.crash = 1'b0;
    bus.pass  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    expect_now("reset", snap(2'd0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0));
    tick();

    // Game 1: start, held button, pass hold, flap, crash with pass+btn.
    bus.btn = 1'b1;
    expect_next("start", snap(2'd1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0));
    tick();
    expect_next("init_one_cycle", snap(2'd1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0));
    tick();
    bus.btn = 1'b0;
    bus.pass = 1'b1;
    repeat (5) tick();
    bus.pass = 1'b0;
    tick();
    bus.pass = 1'b1;
    repeat (3) tick();
    bus.pass = 1'b0;
    expect_now("pass_hold", snap(2'd1, 1'b0, 1'b0, 12'h002, 12'h000, 1'b0));
    tick();
    bus.btn = 1'b1;
    expect_next("flap", snap(2'd1, 1'b0, 1'b1, 12'h002, 12'h000, 1'b0));
    tick();
    bus.btn = 1'b0;
    expect_next("flap_one_cycle", snap(2'd1, 1'b0, 1'b0, 12'h002, 12'h000, 1'b0));
    tick();
    pass_pulse(3);
    crash_it(12'h005, 12'h000);
    die_over(12'h005, 12'h000, 12'h005, 1'b1);
    unlock(12'h005, 12'h005, 1'b1);

    // Game 2: score 7 beats best 5.
    start_game("start2", 12'h005);
    pass_pulse(7);
    crash_it(12'h007, 12'h005);
    die_over(12'h007, 12'h005, 12'h007, 1'b1);
    unlock(12'h007, 12'h007, 1'b1);

    // Game 3: score 2 does not beat best 7.
    start_game("start3", 12'h007);
    pass_pulse(2);
    crash_it(12'h002, 12'h007);
    die_over(12'h002, 12'h007, 12'h007, 1'b0);
    unlock(12'h002, 12'h007, 1'b0);

    // Game 4: BCD carries, saturation, then reset mid-game.
    start_game("start4", 12'h007);
    pass_pulse(99);
    expect_now("score_099", snap(2'd1, 1'b0, 1'b0, 12'h099, 12'h007, 1'b0));
    pass_pulse(1);
    expect_now("score_100", snap(2'd1, 1'b0, 1'b0, 12'h100, 12'h007, 1'b0));
    pass_pulse(899);
    expect_now("score_999", snap(2'd1, 1'b0, 1'b0, 12'h999, 12'h007, 1'b0));
    pass_pulse(1);
    expect_now("score_sat", snap(2'd1, 1'b0, 1'b0, 12'h999, 12'h007, 1'b0));
    rst_n = 1'b0;
    bus.btn = 1'b1;
    expect_next("reset_mid", snap(2'd0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0));
    tick();
    rst_n = 1'b1;
    bus.btn = 1'b0;
    tick();
    expect_now("post_reset_idle", snap(2'd0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0));
    repeat (3) tick();

    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
